vram_write_scheduler: RTL and testbench

Owns write port A of the 320x240 monochrome VRAM (16-bit words, 4800 deep) and shares it between two word-write requesters and a built-in clear engine. Requesters use valid/ready handshakes and are served round-robin. An optional blank-only mode defers writes to vertical blanking to prevent tearing. Read port B stays with the display path; this block only drives the port A enable, write-enable, address and data pins.

---
 rtl/vga_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 40 ++++
 rtl/vram_write_scheduler.sv | 133 +++++++++++++
 tb/tb_vram_write_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/VRAM constants and the write-scheduler state type.
// The VRAM instantiation and the write scheduler both size themselves from here.
package vga_pkg;

  localparam int DATA_WIDTH         = 16;
  localparam int VRAM_DEPTH         = 4800;
  localparam int VRAM_ADDRESS_WIDTH = $clog2(VRAM_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vram_sched_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered preference pointer.
// The pointer flips to the loser after every grant so neither side can be starved.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (req[ptr_q]) begin
      grant[ptr_q] = 1'b1;
    end else if (req[~ptr_q]) begin
      grant[~ptr_q] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[0]) begin
      ptr_d = 1'b1;
    end else if (grant[1]) begin
      ptr_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// VRAM port-A write scheduler: round-robin between two word writers plus a full-screen clear engine.
// All port-A pins are registered; a handshake in cycle N drives the port in cycle N+1.
module vram_write_scheduler #(
  parameter int DATA_WIDTH = vga_pkg::DATA_WIDTH,
  parameter int DATA_DEPTH = vga_pkg::VRAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_vblank,
  input  logic [1:0]                 i_req_valid,
  output logic [1:0]                 o_req_ready,
  input  logic [1:0][ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] i_req_data,
  input  logic                       i_clear_start,
  input  logic [DATA_WIDTH-1:0]      i_clear_pattern,
  output logic                       o_clear_busy,
  output logic                       o_clear_done,
  output logic                       o_addr_err,
  output logic                       o_ena,
  output logic                       o_wea,
  output logic [ADDR_WIDTH-1:0]      o_addra,
  output logic [DATA_WIDTH-1:0]      o_dia
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  vga_pkg::vram_sched_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic                  ena_q, ena_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [DATA_WIDTH-1:0] dia_q, dia_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  window;
  logic                  arb_en;
  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign window = !BLANK_ONLY || i_vblank;

  // Requesters only compete in IDLE with the window open; a clear start wins its cycle outright.
  assign arb_en = i_resetn && (state_q == vga_pkg::IDLE) && window && !i_clear_start;

  rr_arbiter_2 u_arb (
    .clk   (i_clk),
    .rst_n (i_resetn),
    .req   (i_req_valid & {2{arb_en}}),
    .grant (grant)
  );

  assign sel_addr = i_req_addr[grant[1]];
  assign sel_data = i_req_data[grant[1]];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    ena_d     = 1'b0;
    addra_d   = addra_q;
    dia_d     = dia_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      vga_pkg::IDLE: begin
        if (i_clear_start) begin
          pattern_d = i_clear_pattern;
          cnt_d     = '0;
          state_d   = vga_pkg::CLEAR;
        end else if (|grant) begin
          // Out-of-range words are consumed so the requester never stalls, but never reach the BRAM.
          if ({1'b0, sel_addr} < DEPTH_EXT) begin
            ena_d   = 1'b1;
            addra_d = sel_addr;
            dia_d   = sel_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      vga_pkg::CLEAR: begin
        if (window) begin
          ena_d   = 1'b1;
          addra_d = cnt_q;
          dia_d   = pattern_q;
          if (cnt_q == LAST_ADDR) begin
            state_d = vga_pkg::IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q   <= vga_pkg::IDLE;
      cnt_q     <= '0;
      pattern_q <= '0;
      ena_q     <= 1'b0;
      addra_q   <= '0;
      dia_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      ena_q     <= ena_d;
      addra_q   <= addra_d;
      dia_q     <= dia_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_req_ready  = grant;
  assign o_clear_busy = (state_q == vga_pkg::CLEAR);
  assign o_clear_done = done_q;
  assign o_addr_err   = err_q;
  assign o_ena        = ena_q;
  assign o_wea        = ena_q;
  assign o_addra      = addra_q;
  assign o_dia        = dia_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Randomized bench for vram_write_scheduler (BLANK_ONLY=1) against a cycle-level behavioural model.
// A shadow memory fed from port A stands in for BRAM port B read-back.
module tb_vram_write_scheduler;

  localparam int DEPTH = 4800;
  localparam int AW    = 13;
  localparam int DW    = 16;

  logic                 i_clk = 1'b0;
  logic                 i_resetn;
  logic                 i_vblank;
  logic [1:0]           i_req_valid;
  logic [1:0]           o_req_ready;
  logic [1:0][AW-1:0]   i_req_addr;
  logic [1:0][DW-1:0]   i_req_data;
  logic                 i_clear_start;
  logic [DW-1:0]        i_clear_pattern;
  logic                 o_clear_busy, o_clear_done, o_addr_err;
  logic                 o_ena, o_wea;
  logic [AW-1:0]        o_addra;
  logic [DW-1:0]        o_dia;

  vram_write_scheduler #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH),
    .ADDR_WIDTH (AW),
    .BLANK_ONLY (1'b1)
  ) dut (
    .i_clk           (i_clk),
    .i_resetn        (i_resetn),
    .i_vblank        (i_vblank),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_addr      (i_req_addr),
    .i_req_data      (i_req_data),
    .i_clear_start   (i_clear_start),
    .i_clear_pattern (i_clear_pattern),
    .o_clear_busy    (o_clear_busy),
    .o_clear_done    (o_clear_done),
    .o_addr_err      (o_addr_err),
    .o_ena           (o_ena),
    .o_wea           (o_wea),
    .o_addra         (o_addra),
    .o_dia           (o_dia)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the port must show after each edge.
  bit            m_busy;
  int            m_cnt;
  logic [DW-1:0] m_pat;
  int            m_rr;
  logic          e_ena, e_done, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  function automatic int pick(input logic [1:0] v, input int rr);
    if (v == 2'b11) return rr;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_ready();
    logic [1:0] r;
    int g;
    r = 2'b00;
    if (!i_resetn || m_busy || i_clear_start || !i_vblank) return r;
    g = pick(i_req_valid, m_rr);
    if (g == 0) r = 2'b01;
    if (g == 1) r = 2'b10;
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge i_clk or negedge i_resetn);
      if (!i_resetn) begin
        m_busy = 0; m_cnt = 0; m_pat = '0; m_rr = 0;
        e_ena = 0; e_done = 0; e_err = 0; e_addr = '0; e_data = '0;
      end else begin
        logic [1:0] rdy;
        int g;
        rdy = exp_ready();
        e_ena = 0; e_done = 0; e_err = 0;
        if (!m_busy) begin
          if (i_clear_start) begin
            m_busy = 1; m_cnt = 0; m_pat = i_clear_pattern;
          end else if (rdy != 2'b00) begin
            g = rdy[1] ? 1 : 0;
            m_rr = 1 - g;
            if (int'(i_req_addr[g]) < DEPTH) begin
              e_ena = 1; e_addr = i_req_addr[g]; e_data = i_req_data[g];
            end else begin
              e_err = 1;
            end
          end
        end else if (i_vblank) begin
          e_ena = 1; e_addr = AW'(m_cnt); e_data = m_pat;
          if (m_cnt == DEPTH - 1) begin
            m_busy = 0; e_done = 1;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // Compare process plus shadow memory and clear bookkeeping.
  logic [1:0]    rdy_seen = 2'b00;
  logic [DW-1:0] tb_mem [DEPTH];
  bit            clr_seen [DEPTH];
  int            clear_writes, clear_dups, done_cnt;

  initial begin
    forever begin
      @(negedge i_clk);
      rdy_seen = o_req_ready;
      check("ready",    32'(o_req_ready),  32'(exp_ready()));
      check("ena",      32'(o_ena),        32'(e_ena));
      check("wea",      32'(o_wea),        32'(e_ena));
      check("addra",    32'(o_addra),      32'(e_addr));
      check("dia",      32'(o_dia),        32'(e_data));
      check("busy",     32'(o_clear_busy), 32'(m_busy));
      check("done",     32'(o_clear_done), 32'(e_done));
      check("addr_err", 32'(o_addr_err),   32'(e_err));
      if (o_ena === 1'b1 && int'(o_addra) < DEPTH) begin
        tb_mem[o_addra] = o_dia;
        if (o_clear_busy === 1'b1 || o_clear_done === 1'b1) begin
          clear_writes++;
          if (clr_seen[o_addra]) clear_dups++;
          clr_seen[o_addra] = 1;
        end
      end
      if (o_clear_done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Random requesters that hold address/data while waiting for ready.
  task automatic drive_reqs(input int pvalid, input bit allow_oor);
    for (int k = 0; k < 2; k++) begin
      if (!(i_req_valid[k] && !rdy_seen[k])) begin
        i_req_valid[k] = ($urandom_range(99) < pvalid);
        if (allow_oor && $urandom_range(15) == 0) i_req_addr[k] = AW'(DEPTH + $urandom_range(3000));
        else i_req_addr[k] = AW'($urandom_range(DEPTH - 1));
        i_req_data[k] = DW'($urandom);
      end
    end
  endtask

  task automatic run_clear(input logic [DW-1:0] pat, input bit toggle, output int busy_cycles);
    int bad;
    for (int i = 0; i < DEPTH; i++) clr_seen[i] = 0;
    clear_writes = 0; clear_dups = 0; done_cnt = 0;
    i_clear_start = 1'b1; i_clear_pattern = pat;
    drive_reqs(50, 0);
    tick();
    i_clear_start = 1'b0; i_clear_pattern = DW'($urandom);
    busy_cycles = 0;
    while (o_clear_busy && busy_cycles < 20000) begin
      busy_cycles++;
      if (toggle && busy_cycles % 100 == 0) i_vblank = ~i_vblank;
      drive_reqs(50, 0);
      tick();
    end
    check("clear_timeout", 32'(busy_cycles < 20000), 32'd1);
    tick();
    check("clear_writes", 32'(clear_writes), 32'(DEPTH));
    check("clear_dups",   32'(clear_dups),   32'd0);
    check("clear_done",   32'(done_cnt),     32'd1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== pat) bad++;
    check("clear_fill",   32'(bad),          32'd0);
  endtask

  initial begin
    int g0, g1, consec, nrdy, nwr, bc;
    logic [1:0] prev, r;

    for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
    i_resetn = 1'b0; i_vblank = 1'b1; i_req_valid = 2'b11;
    i_req_addr = '0; i_req_data = '0; i_clear_start = 1'b0; i_clear_pattern = '0;
    repeat (3) tick();
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_ena",   32'(o_ena),       32'd0);
    check("rst_addra", 32'(o_addra),     32'd0);
    check("rst_dia",   32'(o_dia),       32'd0);
    check("rst_busy",  32'(o_clear_busy), 32'd0);
    i_req_valid = 2'b00;
    i_resetn = 1'b1;
    tick();

    // Single requester: ready same cycle, write next cycle.
    i_req_valid = 2'b01; i_req_addr[0] = 13'd5; i_req_data[0] = 16'hA5A5;
    #1 check("single_ready", 32'(o_req_ready), 32'h1);
    tick();
    i_req_valid = 2'b00;
    check("single_ena",   32'(o_ena),   32'd1);
    check("single_addra", 32'(o_addra), 32'd5);
    check("single_dia",   32'(o_dia),   32'hA5A5);
    tick();
    check("single_readback", 32'(tb_mem[5]), 32'hA5A5);

    // Contention: both valid for 100 cycles must alternate.
    g0 = 0; g1 = 0; consec = 0; prev = 2'b00;
    for (int i = 0; i < 100; i++) begin
      i_req_valid = 2'b11;
      for (int k = 0; k < 2; k++) begin
        i_req_addr[k] = AW'($urandom_range(DEPTH - 1));
        i_req_data[k] = DW'($urandom);
      end
      #1 r = o_req_ready;
      if (r == 2'b01) g0++;
      if (r == 2'b10) g1++;
      if (r == prev) consec++;
      prev = r;
      tick();
    end
    check("rr_grants0",  32'(g0),     32'd50);
    check("rr_grants1",  32'(g1),     32'd50);
    check("rr_repeats",  32'(consec), 32'd0);

    // Blank gating: window closed holds off a pending request.
    i_vblank = 1'b0; i_req_valid = 2'b01; i_req_addr[0] = 13'd77; i_req_data[0] = 16'h1234;
    nrdy = 0; nwr = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (o_req_ready != 2'b00) nrdy++;
      if (i > 0 && o_ena) nwr++;
      tick();
    end
    check("gate_ready", 32'(nrdy), 32'd0);
    check("gate_writes", 32'(nwr), 32'd0);
    i_vblank = 1'b1;
    #1 check("vblank_ready", 32'(o_req_ready), 32'h1);
    tick();
    i_req_valid = 2'b00;
    check("vblank_ena",   32'(o_ena),   32'd1);
    check("vblank_addra", 32'(o_addra), 32'd77);
    check("vblank_dia",   32'(o_dia),   32'h1234);

    // Out-of-range request: consumed, not written, error pulse.
    i_req_valid = 2'b10; i_req_addr[1] = 13'd4800; i_req_data[1] = 16'hDEAD;
    #1 check("oor_ready", 32'(o_req_ready), 32'h2);
    tick();
    i_req_valid = 2'b00;
    check("oor_ena", 32'(o_ena),      32'd0);
    check("oor_err", 32'(o_addr_err), 32'd1);
    tick();
    check("oor_err_clr", 32'(o_addr_err), 32'd0);

    // Random traffic with the window flickering.
    for (int i = 0; i < 1500; i++) begin
      i_vblank = ($urandom_range(9) < 7);
      drive_reqs(60, 1);
      tick();
    end

    // Clear with the window always open.
    i_vblank = 1'b1;
    run_clear(16'hFFFF, 1'b0, bc);
    check("clear_busy_cycles", 32'(bc), 32'(DEPTH));

    // Clear with the window toggling every 100 cycles.
    run_clear(16'h5A3C, 1'b1, bc);
    check("clear_gap_longer", 32'(bc > DEPTH), 32'd1);

    // Async reset in the middle of a clear.
    i_vblank = 1'b1; i_req_valid = 2'b00;
    done_cnt = 0;
    i_clear_start = 1'b1; i_clear_pattern = 16'h0F0F;
    tick();
    i_clear_start = 1'b0;
    repeat (300) tick();
    #2 i_resetn = 1'b0;
    #1;
    check("abort_ena",   32'(o_ena),        32'd0);
    check("abort_busy",  32'(o_clear_busy), 32'd0);
    check("abort_addra", 32'(o_addra),      32'd0);
    check("abort_dia",   32'(o_dia),        32'd0);
    check("abort_done",  32'(o_clear_done), 32'd0);
    tick();
    i_resetn = 1'b1;
    tick();
    check("abort_kept0",   32'(tb_mem[0]),    32'h0F0F);
    check("abort_kept250", 32'(tb_mem[250]),  32'h0F0F);
    check("abort_old4000", 32'(tb_mem[4000]), 32'h5A3C);
    check("abort_no_done", 32'(done_cnt),     32'd0);

    // Tail of random traffic after the aborted clear.
    for (int i = 0; i < 1000; i++) begin
      i_vblank = ($urandom_range(9) < 6);
      drive_reqs(70, 1);
      tick();
    end
    i_req_valid = 2'b00;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
